// File: rtl/local_store_controller_pkg.sv
// rtl/local_store_controller_pkg.sv - shared state encoding and skid sizing for the local store controller
package local_store_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } lsc_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/local_store_skid.sv
// rtl/local_store_skid.sv - two-entry FIFO that absorbs SRAM read returns in front of the replay stream
module local_store_skid
    import local_store_controller_pkg::*;
#(
    parameter int DW = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    output logic [DW-1:0]         head_data,
    output logic [SKID_CNT_W-1:0] count,
    output logic                  empty
);

    logic [DW-1:0]         ent_q [SKID_DEPTH];
    logic [DW-1:0]         ent_d [SKID_DEPTH];
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic [SKID_CNT_W-1:0] count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign head_data = ent_q[rptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);

    // Next-state for entries, pointers and occupancy; a pop frees a slot for a same-cycle push
    always_comb begin
        ent_d   = ent_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != SKID_CNT_W'(SKID_DEPTH)) || do_pop);
        if (do_push) begin
            ent_d[wptr_q] = push_data;
            wptr_d        = ~wptr_q;
        end
        if (do_pop) begin
            rptr_d = ~rptr_q;
        end
        count_d = count_q + SKID_CNT_W'(do_push) - SKID_CNT_W'(do_pop);
    end

    // FIFO state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/local_store_controller.sv
// rtl/local_store_controller.sv - fills the PE local store from a stream and replays it a programmable number of times
module local_store_controller
    import local_store_controller_pkg::*;
#(
    parameter int A = 7,
    parameter int W = 16,
    parameter int R = 8
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         start,
    input  logic [A:0]   len,
    input  logic [R-1:0] reps,
    output logic         busy,
    output logic         done,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [A-1:0] mem_address,
    output logic [W-1:0] mem_dataInput,
    output logic         mem_write,
    input  logic [W-1:0] mem_dataOutput
);

    lsc_state_t            state_q, state_d;
    logic [A:0]            len_q, len_d;
    logic [R-1:0]          reps_q, reps_d;
    logic [A:0]            wr_ptr_q, wr_ptr_d;
    logic [A:0]            rd_ptr_q, rd_ptr_d;
    logic [R-1:0]          pass_q, pass_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;

    logic [A:0]            last_idx;
    logic [SKID_CNT_W-1:0] skid_count;
    logic                  skid_empty;
    logic [W:0]            skid_head;
    logic                  pop;
    logic [SKID_CNT_W:0]   occ;
    logic                  can_issue;

    // A read issued last cycle lands in the skid now, tagged with its end-of-pass flag
    local_store_skid #(
        .DW(W + 1)
    ) u_skid (
        .clk       (CLK),
        .rst_n     (RESETn),
        .push      (inflight_q),
        .push_data ({inflight_last_q, mem_dataOutput}),
        .pop       (pop),
        .head_data (skid_head),
        .count     (skid_count),
        .empty     (skid_empty)
    );

    assign last_idx      = len_q - (A + 1)'(1);
    assign out_valid     = ~skid_empty;
    assign out_data      = skid_head[W-1:0];
    assign out_last      = out_valid & skid_head[W];
    assign pop           = out_valid & out_ready;
    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_dataInput = in_data;

    // Slots committed after this cycle: buffered plus in flight, less the word leaving now
    assign occ       = {1'b0, skid_count} + (SKID_CNT_W + 1)'(inflight_q);
    assign can_issue = (occ - (SKID_CNT_W + 1)'(pop)) < (SKID_CNT_W + 1)'(SKID_DEPTH);

    // Job sequencing: next state, pointers and SRAM port controls
    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        reps_d          = reps_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        pass_d          = pass_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        in_ready        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = len;
                    reps_d   = reps;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    pass_d   = '0;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                in_ready    = 1'b1;
                mem_address = wr_ptr_q[A-1:0];
                if (in_valid) begin
                    mem_write = 1'b1;
                    if (wr_ptr_q == last_idx) begin
                        wr_ptr_d = '0;
                        state_d  = (reps_q != '0) ? ST_READ : ST_DRAIN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + (A + 1)'(1);
                    end
                end
            end

            ST_READ: begin
                mem_address = rd_ptr_q[A-1:0];
                if (can_issue) begin
                    inflight_d      = 1'b1;
                    inflight_last_d = (rd_ptr_q == last_idx);
                    if (rd_ptr_q == last_idx) begin
                        rd_ptr_d = '0;
                        pass_d   = pass_q + R'(1);
                        if (pass_q == reps_q - R'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + (A + 1)'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (skid_empty && !inflight_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q         <= ST_IDLE;
            len_q           <= '0;
            reps_q          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            pass_q          <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            reps_q          <= reps_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            pass_q          <= pass_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

endmodule

// File: tb/tb_local_store_controller.sv
// tb/tb_local_store_controller.sv - directed self-checking bench for local_store_controller
module tb_local_store_controller;

    localparam int A = 7;
    localparam int W = 16;
    localparam int R = 8;

    logic         CLK = 1'b0;
    logic         RESETn = 1'b0;
    logic         start = 1'b0;
    logic [A:0]   len = '0;
    logic [R-1:0] reps = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic [A-1:0] mem_address;
    logic [W-1:0] mem_dataInput;
    logic         mem_write;
    logic [W-1:0] mem_dataOutput;

    logic [W-1:0] sram [0:(1<<A)-1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int ob_data[$];
    bit ob_last[$];
    int ob_cyc[$];

    local_store_controller #(.A(A), .W(W), .R(R)) dut (
        .CLK            (CLK),
        .RESETn         (RESETn),
        .start          (start),
        .len            (len),
        .reps           (reps),
        .busy           (busy),
        .done           (done),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .mem_address    (mem_address),
        .mem_dataInput  (mem_dataInput),
        .mem_write      (mem_write),
        .mem_dataOutput (mem_dataOutput)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // One-cycle-latency SRAM
    always @(posedge CLK) begin
        if (mem_write) sram[mem_address] <= mem_dataInput;
        mem_dataOutput <= sram[mem_address];
    end

    // Passive log of port activity, sampled mid-cycle
    always @(negedge CLK) begin
        if (RESETn) begin
            if (mem_write) begin
                wr_addr.push_back(int'(mem_address));
                wr_data.push_back(int'(mem_dataInput));
                wr_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                ob_data.push_back(int'(out_data));
                ob_last.push_back(out_last);
                ob_cyc.push_back(cyc);
            end
            if (out_valid) valid_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic start_job(input int l, input int r);
        @(posedge CLK); #1;
        start = 1'b1; len = (A+1)'(l); reps = R'(r);
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    // Must be entered just after a rising edge
    task automatic fill(input int n, input int base);
        int i = 0;
        int guard = 0;
        bit f;
        in_valid = 1'b1; in_data = W'(base);
        while (i < n && guard < 2000) begin
            @(negedge CLK); guard++;
            f = in_ready;
            @(posedge CLK); #1;
            if (f) begin i++; in_data = W'(base + i); end
        end
        in_valid = 1'b0;
        checks++;
        if (i != n) begin failures++; $display("FAIL fill_count got=%0d want=%0d", i, n); end
    endtask

    task automatic run_until_done(input bit toggle, input int budget);
        int d0 = done_cnt;
        int n = 0;
        int tail = -1;
        while (n < budget && tail != 0) begin
            @(posedge CLK); #1;
            if (toggle) out_ready = ~out_ready;
            @(negedge CLK); #1;
            n++;
            if (tail > 0) tail--;
            else if (tail < 0 && done_cnt != d0) tail = 4;
        end
        out_ready = 1'b1;
        checks++;
        if (done_cnt == d0) begin failures++; $display("FAIL done_timeout got=0 want=1 after %0d cycles", n); end
    endtask

    task automatic test_reset();
        RESETn = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({busy, done, in_ready, out_valid, out_last, mem_write} !== 6'b0) begin
            failures++; $display("FAIL reset_outputs got=%b want=000000", {busy, done, in_ready, out_valid, out_last, mem_write});
        end
        checks++;
        if (mem_address !== '0) begin failures++; $display("FAIL reset_addr got=%0d want=0", mem_address); end
        @(posedge CLK); #1; RESETn = 1'b1;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b in_ready=%b want 0 0", busy, in_ready); end
    endtask

    task automatic test_basic();
        int wb = wr_addr.size();
        int ob = ob_data.size();
        int d0 = done_cnt;
        out_ready = 1'b1;
        start_job(4, 2);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy); end
        fill(4, 'hA0);
        run_until_done(1'b0, 100);
        checks++;
        if (wr_addr.size() - wb != 4) begin failures++; $display("FAIL basic_wr_count got=%0d want=4", wr_addr.size() - wb); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr[wb+i] != i || wr_data[wb+i] != 'hA0 + i) begin
                    failures++; $display("FAIL basic_wr[%0d] got addr=%0d data=%h want addr=%0d data=%h", i, wr_addr[wb+i], wr_data[wb+i], i, 'hA0 + i);
                end
            end
        end
        checks++;
        if (ob_data.size() - ob != 8) begin failures++; $display("FAIL basic_out_count got=%0d want=8", ob_data.size() - ob); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (ob_data[ob+i] != 'hA0 + (i % 4) || ob_last[ob+i] != (i % 4 == 3)) begin
                    failures++; $display("FAIL basic_out[%0d] got data=%h last=%0d want data=%h last=%0d", i, ob_data[ob+i], ob_last[ob+i], 'hA0 + (i % 4), (i % 4 == 3));
                end
            end
            checks++;
            if (ob_cyc[ob] - wr_cyc[wb+3] != 3) begin failures++; $display("FAIL basic_latency got=%0d want=3", ob_cyc[ob] - wr_cyc[wb+3]); end
            checks++;
            if (ob_cyc[ob+7] - ob_cyc[ob] != 7) begin failures++; $display("FAIL basic_throughput got=%0d want=7", ob_cyc[ob+7] - ob_cyc[ob]); end
        end
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_count got=%0d want=1", done_cnt - d0); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_backpressure();
        int ob = ob_data.size();
        int d0 = done_cnt;
        out_ready = 1'b1;
        start_job(4, 2);
        fill(4, 'hA0);
        run_until_done(1'b1, 200);
        checks++;
        if (ob_data.size() - ob != 8) begin failures++; $display("FAIL bp_out_count got=%0d want=8", ob_data.size() - ob); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (ob_data[ob+i] != 'hA0 + (i % 4) || ob_last[ob+i] != (i % 4 == 3)) begin
                    failures++; $display("FAIL bp_out[%0d] got data=%h last=%0d want data=%h last=%0d", i, ob_data[ob+i], ob_last[ob+i], 'hA0 + (i % 4), (i % 4 == 3));
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL bp_done_count got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_zero_len();
        int wb = wr_addr.size();
        int v0 = valid_cnt;
        int d0 = done_cnt;
        start_job(0, 5);
        @(negedge CLK);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b want=1", done); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b want=0", busy); end
        repeat (4) @(negedge CLK);
        #1;
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL zero_done_count got=%0d want=1", done_cnt - d0); end
        checks++;
        if (wr_addr.size() != wb) begin failures++; $display("FAIL zero_writes got=%0d want=0", wr_addr.size() - wb); end
        checks++;
        if (valid_cnt != v0) begin failures++; $display("FAIL zero_valid got=%0d want=0", valid_cnt - v0); end
    endtask

    task automatic test_full_depth();
        int wb = wr_addr.size();
        int ob = ob_data.size();
        int bad;
        out_ready = 1'b1;
        start_job(128, 1);
        fill(128, 'h1000);
        run_until_done(1'b0, 400);
        checks++;
        if (wr_addr.size() - wb != 128) begin failures++; $display("FAIL full_wr_count got=%0d want=128", wr_addr.size() - wb); end
        else begin
            bad = 0;
            for (int i = 0; i < 128; i++)
                if (wr_addr[wb+i] != i || wr_data[wb+i] != 'h1000 + i) bad++;
            checks++;
            if (bad != 0) begin failures++; $display("FAIL full_wr_content got=%0d bad want=0", bad); end
        end
        checks++;
        if (ob_data.size() - ob != 128) begin failures++; $display("FAIL full_out_count got=%0d want=128", ob_data.size() - ob); end
        else begin
            bad = 0;
            for (int i = 0; i < 128; i++)
                if (ob_data[ob+i] != 'h1000 + i) bad++;
            checks++;
            if (bad != 0) begin failures++; $display("FAIL full_out_data got=%0d bad want=0", bad); end
            bad = 0;
            for (int i = 0; i < 128; i++)
                if (ob_last[ob+i] != (i == 127)) bad++;
            checks++;
            if (bad != 0) begin failures++; $display("FAIL full_out_last got=%0d bad want=0", bad); end
        end
    endtask

    task automatic test_ignored_inputs();
        int wb = wr_addr.size();
        int ob = ob_data.size();
        int d0 = done_cnt;
        out_ready = 1'b0;
        start_job(4, 3);
        fill(4, 'hC0);
        repeat (4) @(posedge CLK);
        #1;
        start = 1'b1; len = (A+1)'(1); reps = R'(1); in_valid = 1'b1; in_data = 'hFFFF;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL ign_fill got in_ready=%b mem_write=%b want 0 0", in_ready, mem_write); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00C0) begin failures++; $display("FAIL ign_stall_head got valid=%b data=%h want 1 00c0", out_valid, out_data); end
        @(posedge CLK); #1;
        start = 1'b0;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL ign_busy got busy=%b mem_write=%b want 1 0", busy, mem_write); end
        in_valid = 1'b0;
        @(posedge CLK); #1;
        out_ready = 1'b1;
        run_until_done(1'b0, 200);
        checks++;
        if (wr_addr.size() - wb != 4) begin failures++; $display("FAIL ign_wr_count got=%0d want=4", wr_addr.size() - wb); end
        checks++;
        if (ob_data.size() - ob != 12) begin failures++; $display("FAIL ign_out_count got=%0d want=12", ob_data.size() - ob); end
        else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (ob_data[ob+i] != 'hC0 + (i % 4) || ob_last[ob+i] != (i % 4 == 3)) begin
                    failures++; $display("FAIL ign_out[%0d] got data=%h last=%0d want data=%h last=%0d", i, ob_data[ob+i], ob_last[ob+i], 'hC0 + (i % 4), (i % 4 == 3));
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL ign_done_count got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_read();
        int ob = ob_data.size();
        int d0;
        int g = 0;
        out_ready = 1'b1;
        start_job(4, 2);
        fill(4, 'hB0);
        while (ob_data.size() - ob < 3 && g < 100) begin
            @(negedge CLK); #1; g++;
        end
        checks++;
        if (ob_data.size() - ob != 3) begin failures++; $display("FAIL rst_pre_outputs got=%0d want=3", ob_data.size() - ob); end
        d0 = done_cnt;
        RESETn = 1'b0;
        #1;
        checks++;
        if ({busy, done, in_ready, out_valid, out_last, mem_write} !== 6'b0 || mem_address !== '0) begin
            failures++; $display("FAIL rst_mid_outputs got=%b addr=%0d want=000000 addr=0", {busy, done, in_ready, out_valid, out_last, mem_write}, mem_address);
        end
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESETn = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_abandon got done_pulses=%0d busy=%b out_valid=%b want 0 0 0", done_cnt - d0, busy, out_valid);
        end
        ob = ob_data.size();
        d0 = done_cnt;
        @(posedge CLK); #1;
        start_job(2, 1);
        fill(2, 'h55);
        run_until_done(1'b0, 100);
        checks++;
        if (ob_data.size() - ob != 2) begin failures++; $display("FAIL rst_new_count got=%0d want=2", ob_data.size() - ob); end
        else begin
            checks++;
            if (ob_data[ob] != 'h55 || ob_last[ob] != 1'b0 || ob_data[ob+1] != 'h56 || ob_last[ob+1] != 1'b1) begin
                failures++; $display("FAIL rst_new_data got %h/%0d %h/%0d want 55/0 56/1", ob_data[ob], ob_last[ob], ob_data[ob+1], ob_last[ob+1]);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL rst_new_done got=%0d want=1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_full_depth();
        test_ignored_inputs();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/local_store_controller.md
Name: local_store_controller

Overview:
Drives the per-PE local store SRAM port: it sequences address, write enable and write data on behalf of the PE datapath. The block fills the store from an incoming valid/ready stream, then replays the stored words in address order as an outgoing valid/ready stream, a configurable number of times (weight/ifmap reuse). It sits between the PE's operand network and the local store, and hides the SRAM's one-cycle read latency behind a 2-entry skid buffer.

Parameters:
A, 7, local store address width; depth = 2^A words
W, 16, data word width
R, 8, width of repeat count

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a job (sampled only in IDLE)
len  in  A+1  words per job, 0..2^A; captured on start
reps  in  R  number of replay passes; captured on start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job end
in_data  in  W  fill stream data
in_valid  in  1  fill stream valid
in_ready  out  1  high only in FILL
out_data  out  W  replay stream data (skid head)
out_valid  out  1  replay stream valid
out_ready  in  1  replay stream ready
out_last  out  1  high with last word of each pass
mem_address  out  A  to store address
mem_dataInput  out  W  to store dataInput (= in_data)
mem_write  out  1  to store write
mem_dataOutput  in  W  from store dataOutput; valid the cycle after a read address is presented

Behaviour:
- Reset (async, RESETn=0): state IDLE; pointers, counters, skid buffer cleared; busy, done, in_ready, out_valid, out_last, mem_write = 0; mem_address = 0. Reset mid-job abandons the job; no done.
- States: IDLE, FILL, READ, DRAIN.
- IDLE: start=1 captures len/reps, busy=1 next cycle. len=0 -> no FILL/READ, done pulses the cycle after start. Otherwise -> FILL.
- FILL: in_ready=1; a word transfers when in_valid&in_ready: mem_write=1, mem_address=wr_ptr, wr_ptr++. After word len-1 -> READ if reps>0, else DRAIN (done next cycle). mem_write is combinational on in_valid in FILL only.
- READ: issue a read (mem_address=rd_ptr) when skid occupancy + in-flight reads < 2; the read returns into the skid the next cycle. rd_ptr wraps len-1 -> 0 and the pass counter increments; after the last word of pass reps-1 no more reads issue -> DRAIN.
- Skid: 2 entries, FIFO order; out_valid = non-empty; pop on out_valid&out_ready; a simultaneous pop and return are allowed. Each entry carries a last flag (set for address len-1). Throughput is 1 word/cycle with out_ready held high; out_ready=0 never loses or duplicates a word.
- DRAIN: wait until skid is empty and nothing is in flight; done=1 for one cycle, busy=0, -> IDLE.
- start outside IDLE is ignored. in_valid outside FILL is ignored (in_ready=0).
- Latency: first out_valid appears 2 cycles after entering READ.
- Counters: wr_ptr/rd_ptr are A+1 bits internally, compared to len; mem_address = low A bits. len=2^A is legal.

Decomposition:
- Shared package: state encoding constants (IDLE, FILL, READ, DRAIN) and the skid depth constant (2).
- One sub-module: local_store_skid (2-entry FIFO, W+1 bits wide, push/pop/count).

Test Plan:
- len=4, reps=2, fill 0xA0..0xA3, out_ready=1 -> mem_write on addresses 0..3; out sequence A0,A1,A2,A3,A0..A3; out_last on 4th and 8th; exactly one done.
- Same job with out_ready toggling 1010 -> identical 8-word sequence, no drop/dup; no more than 2 reads outstanding + buffered.
- len=0 -> done the cycle after start, mem_write never asserted, out_valid never asserted.
- len=128 (A=7), reps=1 -> addresses 0..127 written, replay wraps correctly, last=1 only on the word from address 127.
- start pulsed during READ -> ignored; in_valid=1 during READ -> in_ready=0, no mem_write.
- RESETn low mid-READ after 3 outputs -> all outputs 0 immediately, state IDLE; new job len=2, reps=1 runs cleanly.
